// File: rtl/ahb_subordinate_mem.sv
// rtl/ahb_subordinate_mem.sv - AHB5-lite word memory subordinate with wait states, byte lanes and ERROR response
module ahb_subordinate_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hreadyout,
  output logic                    hresp
);
  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam int IDX_W     = ADDR_WIDTH - LANE_BITS;
  localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [2:0]             size_q, size_d;
  logic [LANE_BITS-1:0]   low_q, low_d;
  logic [MEM_AW-1:0]      idx_q, idx_d;
  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0]  hrdata_q, hrdata_d;

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic                   accept;
  logic                   acc_err;
  logic [IDX_W-1:0]       acc_idx;
  logic [2:0]             align_mask;
  logic                   wr_en;
  logic [NB-1:0]          lane_en;
  logic [DATA_WIDTH-1:0]  cur_word;
  logic [DATA_WIDTH-1:0]  wr_word;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic                   unused_ok;

  assign unused_ok = ^{hburst, hprot, htrans[0]};

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

  // Address-phase qualification and the three error checks done at accept time
  always_comb begin
    accept     = hsel && hready && htrans[1];
    acc_idx    = haddr[ADDR_WIDTH-1:LANE_BITS];
    align_mask = (3'b001 << hsize) - 3'b001;
    acc_err    = (hsize > 3'(LANE_BITS))
              || ((haddr[2:0] & align_mask) != 3'b000)
              || (acc_idx >= IDX_W'(MEM_DEPTH));
  end

  // Write merge: only lanes inside the registered size window and strobed this cycle change
  always_comb begin
    wr_en    = (state_q == S_DATA) && write_q;
    cur_word = mem[idx_q];
    lane_en  = '0;
    wr_word  = cur_word;
    for (int i = 0; i < NB; i++) begin
      if ((i >= int'(low_q)) && (i < int'(low_q) + (1 << size_q))) begin
        lane_en[i] = hwstrb[i];
      end
      if (lane_en[i]) begin
        wr_word[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  // Next-state, captured transfer attributes and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    low_d   = low_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) begin
          write_d = hwrite;
          size_d  = hsize;
          low_d   = haddr[LANE_BITS-1:0];
          idx_d   = acc_idx[MEM_AW-1:0];
          if (acc_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DATA;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    // A read entering DATA on the same edge a write commits must see the merged word
    rd_word = mem[idx_d];
    if (wr_en && (idx_d == idx_q)) begin
      rd_word = wr_word;
    end

    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    hrdata_d    = ((state_d == S_DATA) && !write_d) ? rd_word : '0;
  end

  // Control state and registered bus outputs
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      low_q       <= '0;
      idx_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      size_q      <= size_d;
      low_q       <= low_d;
      idx_q       <= idx_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Memory array, not reset; a reset pulls state out of DATA so a pending write is dropped
  always_ff @(posedge hclk) begin
    if (wr_en) begin
      mem[idx_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// tb/tb_ahb_subordinate_mem.sv - randomized AHB memory subordinate bench with behavioural reference model
module tb_ahb_subordinate_mem;
  localparam int NI = 3;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic hclk   = 1'b0;
  logic hreset = 1'b0;
  logic [2:0] hburst = 3'b000;
  logic [3:0] hprot  = 4'b0011;

  logic [NI-1:0]       hsel_v, hwrite_v, hold_v;
  logic [NI-1:0]       hready_v, hreadyout_v, hresp_v;
  logic [NI-1:0][1:0]  htrans_p;
  logic [NI-1:0][2:0]  hsize_p;
  logic [NI-1:0][31:0] haddr_p, hwdata_p, hrdata_p;
  logic [NI-1:0][3:0]  hwstrb_p;

  int vectors     = 0;
  int miscompares = 0;

  always #5 hclk = ~hclk;

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] got %h expected %h", nm, k, act, exp);
    end
  endtask

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int WS = (k == 0) ? 0 : ((k == 1) ? 2 : 3);

    assign hready_v[k] = hreadyout_v[k] & ~hold_v[k];

    ahb_subordinate_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (256),
      .WAIT_STATES(WS)
    ) u_dut (
      .hclk     (hclk),
      .hreset   (hreset),
      .hsel     (hsel_v[k]),
      .haddr    (haddr_p[k]),
      .htrans   (htrans_p[k]),
      .hwrite   (hwrite_v[k]),
      .hsize    (hsize_p[k]),
      .hburst   (hburst),
      .hprot    (hprot),
      .hwdata   (hwdata_p[k]),
      .hwstrb   (hwstrb_p[k]),
      .hready   (hready_v[k]),
      .hrdata   (hrdata_p[k]),
      .hreadyout(hreadyout_v[k]),
      .hresp    (hresp_v[k])
    );

    // Reference: byte-addressed memory plus the one transfer currently in its data phase
    logic [7:0]  ref_mem [1024];
    bit          cur_valid = 1'b0;
    bit          cur_err, cur_wr, done;
    int unsigned cur_addr, s_addr, base, a;
    int          cur_size, cur_age, s_size;
    bit          s_acc, s_wr, exp_rdy, exp_resp;
    logic [31:0] s_wdata, exp_rd;
    logic [3:0]  s_strb;

    always @(negedge hclk) begin
      exp_rdy  = 1'b1;
      exp_resp = 1'b0;
      exp_rd   = '0;
      if (cur_valid) begin
        if (cur_err) begin
          exp_resp = 1'b1;
          exp_rdy  = (cur_age >= 1);
        end else if (cur_age < WS) begin
          exp_rdy = 1'b0;
        end else if (!cur_wr) begin
          base   = cur_addr & ~32'h3;
          exp_rd = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        end
      end
      check("hreadyout", k, 32'(hreadyout_v[k]), 32'(exp_rdy));
      check("hresp",     k, 32'(hresp_v[k]),     32'(exp_resp));
      check("hrdata",    k, hrdata_p[k],         exp_rd);
      s_acc   = hsel_v[k] && !hold_v[k] && htrans_p[k][1] && exp_rdy && !hreset;
      s_wr    = hwrite_v[k];
      s_addr  = haddr_p[k];
      s_size  = int'(hsize_p[k]);
      s_wdata = hwdata_p[k];
      s_strb  = hwstrb_p[k];
    end

    always @(posedge hclk or posedge hreset) begin
      if (hreset) begin
        cur_valid = 1'b0;
      end else begin
        done = cur_valid && (cur_age >= (cur_err ? 1 : WS));
        if (done && !cur_err && cur_wr) begin
          for (int b = 0; b < (1 << cur_size); b++) begin
            a = cur_addr + b;
            if (s_strb[a % 4]) ref_mem[a] = s_wdata[8*(a % 4) +: 8];
          end
        end
        if (s_acc) begin
          cur_valid = 1'b1;
          cur_age   = 0;
          cur_wr    = s_wr;
          cur_addr  = s_addr;
          cur_size  = s_size;
          cur_err   = ((1 << s_size) > 4) || ((s_addr % (1 << s_size)) != 0) || ((s_addr / 4) >= 256);
        end else if (done) begin
          cur_valid = 1'b0;
        end else if (cur_valid) begin
          cur_age++;
        end
      end
    end
  end

  // One manager transfer: present the address phase, wait for it to be taken, then drive its write data
  task automatic xfer(input int k, input bit sel, input logic [1:0] tr, input bit wr,
                      input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rd_prev, output logic resp_prev, output int cycles);
    bit rdy;
    hsel_v[k]   = sel;
    htrans_p[k] = tr;
    hwrite_v[k] = wr;
    haddr_p[k]  = addr;
    hsize_p[k]  = size;
    cycles      = 0;
    do begin
      @(negedge hclk);
      rdy       = hready_v[k];
      rd_prev   = hrdata_p[k];
      resp_prev = hresp_v[k];
      @(posedge hclk);
      cycles++;
    end while (!rdy && cycles < 64);
    #1;
    if (!rdy) check("xfer_timeout", k, {31'b0, rdy}, 32'd1);
    hwdata_p[k] = wdata;
    hwstrb_p[k] = strb;
  endtask

  task automatic idle(input int k, output logic [31:0] rd_prev, output logic resp_prev, output int cycles);
    xfer(k, 1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'h0, 4'h0, rd_prev, resp_prev, cycles);
  endtask

  logic [31:0] rd;
  logic        rs;
  int          cy;

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    hsel_v = '0; hwrite_v = '0; hold_v = '0; htrans_p = '0; hsize_p = '0;
    haddr_p = '0; hwdata_p = '0; hwstrb_p = '0;
    #1 hreset = 1'b1;
    repeat (2) @(posedge hclk);
    #2 hreset = 1'b0;
    @(posedge hclk); #1;
    check("reset_hreadyout", 0, 32'(hreadyout_v), 32'h7);
    check("reset_hresp",     0, 32'(hresp_v),     32'h0);
    check("reset_hrdata",    0, hrdata_p[0],      32'h0);

    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < 256; w++) begin
        xfer(k, 1'b1, T_NSEQ, 1'b1, 32'(w * 4), 3'd2, $urandom, 4'hF, rd, rs, cy);
      end
      idle(k, rd, rs, cy);
    end

    // Zero-wait write then read of the same word, pipelined
    xfer(0, 1'b1, T_NSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF, rd, rs, cy);
    xfer(0, 1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0, rd, rs, cy);
    check("pipe_wr_cycles", 0, cy, 1);
    idle(0, rd, rs, cy);
    check("pipe_rd_cycles", 0, cy, 1);
    check("pipe_rdata", 0, rd, 32'hDEADBEEF);
    check("pipe_resp", 0, 32'(rs), 32'h0);

    // Byte lanes: byte write, then a halfword write with no strobes
    xfer(0, 1'b1, T_NSEQ, 1'b1, 32'h20, 3'd2, 32'h11223344, 4'hF, rd, rs, cy);
    xfer(0, 1'b1, T_NSEQ, 1'b1, 32'h22, 3'd0, 32'h00AA0000, 4'hF, rd, rs, cy);
    xfer(0, 1'b1, T_NSEQ, 1'b1, 32'h20, 3'd1, 32'hFFFFFFFF, 4'h0, rd, rs, cy);
    xfer(0, 1'b1, T_NSEQ, 1'b0, 32'h20, 3'd2, 32'h0, 4'h0, rd, rs, cy);
    check("strb0_resp", 0, 32'(rs), 32'h0);
    idle(0, rd, rs, cy);
    check("lanes_rdata", 0, rd, 32'h11AA3344);
    check("lanes_model", 0, {g_inst[0].ref_mem[35], g_inst[0].ref_mem[34],
                             g_inst[0].ref_mem[33], g_inst[0].ref_mem[32]}, 32'h11AA3344);

    // Error responses: misaligned, out of range, oversize
    xfer(0, 1'b1, T_NSEQ, 1'b0, 32'h401, 3'd2, 32'h0, 4'h0, rd, rs, cy);
    idle(0, rd, rs, cy);
    check("misalign_cycles", 0, cy, 2);
    check("misalign_resp", 0, 32'(rs), 32'h1);
    xfer(0, 1'b1, T_NSEQ, 1'b0, 32'h400, 3'd2, 32'h0, 4'h0, rd, rs, cy);
    idle(0, rd, rs, cy);
    check("range_cycles", 0, cy, 2);
    check("range_resp", 0, 32'(rs), 32'h1);
    xfer(0, 1'b1, T_NSEQ, 1'b0, 32'h0, 3'd3, 32'h0, 4'h0, rd, rs, cy);
    idle(0, rd, rs, cy);
    check("dword_resp", 0, 32'(rs), 32'h1);
    check("dword_rdata", 0, rd, 32'h0);

    // IDLE, BUSY and hready-low address phases must leave memory alone
    xfer(0, 1'b1, T_NSEQ, 1'b1, 32'h30, 3'd2, 32'h0BADF00D, 4'hF, rd, rs, cy);
    xfer(0, 1'b1, T_IDLE, 1'b1, 32'h30, 3'd2, 32'h55555555, 4'hF, rd, rs, cy);
    xfer(0, 1'b1, T_BUSY, 1'b1, 32'h30, 3'd2, 32'h77777777, 4'hF, rd, rs, cy);
    check("busy_cycles", 0, cy, 1);
    hsel_v[0] = 1'b1; htrans_p[0] = T_NSEQ; hwrite_v[0] = 1'b1; haddr_p[0] = 32'h30;
    hsize_p[0] = 3'd2; hold_v[0] = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    hsel_v[0] = 1'b0; htrans_p[0] = T_IDLE; hold_v[0] = 1'b0; hwdata_p[0] = 32'h66666666;
    xfer(0, 1'b1, T_NSEQ, 1'b0, 32'h30, 3'd2, 32'h0, 4'h0, rd, rs, cy);
    idle(0, rd, rs, cy);
    check("untouched_rdata", 0, rd, 32'h0BADF00D);

    // Two wait states: single read, then an INCR4 burst
    xfer(1, 1'b1, T_NSEQ, 1'b1, 32'h80, 3'd2, 32'hA5A50001, 4'hF, rd, rs, cy);
    xfer(1, 1'b1, T_NSEQ, 1'b0, 32'h80, 3'd2, 32'h0, 4'h0, rd, rs, cy);
    check("ws_wr_cycles", 1, cy, 3);
    idle(1, rd, rs, cy);
    check("ws_rd_cycles", 1, cy, 3);
    check("ws_rdata", 1, rd, 32'hA5A50001);
    hburst = 3'b011;
    xfer(1, 1'b1, T_NSEQ, 1'b0, 32'h90, 3'd2, 32'h0, 4'h0, rd, rs, cy);
    for (int b = 1; b < 4; b++) begin
      xfer(1, 1'b1, T_SEQ, 1'b0, 32'(32'h90 + b * 4), 3'd2, 32'h0, 4'h0, rd, rs, cy);
      check("burst_beat_cycles", 1, cy, 3);
    end
    idle(1, rd, rs, cy);
    check("burst_last_cycles", 1, cy, 3);
    hburst = 3'b000;

    // Reset in the middle of a wait-stated write drops that write
    xfer(2, 1'b1, T_NSEQ, 1'b1, 32'h40, 3'd2, 32'hCAFEF00D, 4'hF, rd, rs, cy);
    idle(2, rd, rs, cy);
    xfer(2, 1'b1, T_NSEQ, 1'b1, 32'h40, 3'd2, 32'h12345678, 4'hF, rd, rs, cy);
    hsel_v[2] = 1'b0; htrans_p[2] = T_IDLE;
    @(negedge hclk);
    #2 hreset = 1'b1;
    #1;
    check("rst_hreadyout", 2, 32'(hreadyout_v[2]), 32'h1);
    check("rst_hresp", 2, 32'(hresp_v[2]), 32'h0);
    check("rst_hrdata", 2, hrdata_p[2], 32'h0);
    @(negedge hclk);
    #2 hreset = 1'b0;
    @(posedge hclk); #1;
    xfer(2, 1'b1, T_NSEQ, 1'b0, 32'h40, 3'd2, 32'h0, 4'h0, rd, rs, cy);
    idle(2, rd, rs, cy);
    check("rst_old_rdata", 2, rd, 32'hCAFEF00D);

    // Randomized traffic, checked cycle by cycle by the reference model
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 200; n++) begin
        int unsigned r;
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [31:0] ad;
        logic [3:0]  st;
        r  = $urandom_range(99);
        tr = (r < 10) ? T_IDLE : (r < 15) ? T_BUSY : (r < 55) ? T_NSEQ : T_SEQ;
        if ($urandom_range(9) != 0) begin
          sz = 3'($urandom_range(2));
          ad = 32'(($urandom_range(255) << 2) | ($urandom_range(3) & ~((32'd1 << sz) - 32'd1)));
        end else begin
          sz = 3'($urandom_range(3));
          ad = 32'($urandom_range(32'h7FF));
        end
        st = ($urandom_range(1) != 0) ? 4'hF : 4'($urandom_range(15));
        xfer(k, ($urandom_range(9) != 0), tr, ($urandom_range(1) != 0), ad, sz, $urandom, st, rd, rs, cy);
      end
      idle(k, rd, rs, cy);
      idle(k, rd, rs, cy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_subordinate_mem.md
Name: ahb_subordinate_mem

Overview:
- Synthesizable AHB5-lite subordinate: word-organized memory that answers transfers from the manager driven by the master agent.
- Provides the DUT end for slave-agent/monitor checking: configurable wait states, byte-lane writes, and the two-cycle ERROR response.
- Sits behind the address decoder: qualified by hsel, observes the combined hready.

Parameters:
- ADDR_WIDTH, 32, haddr width
- DATA_WIDTH, 32, hwdata/hrdata width (32 or 64)
- MEM_DEPTH, 256, number of DATA_WIDTH words
- WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY data phase (0..15)

Ports:
- hclk  in  1  clock; all state changes on rising edge
- hreset  in  1  asynchronous active-high reset
- hsel  in  1  subordinate select
- haddr  in  ADDR_WIDTH  transfer address
- htrans  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
- hwrite  in  1  1=write
- hsize  in  3  transfer size (BYTE=000 .. LINE32=111)
- hburst  in  3  burst type; accepted, no effect on behaviour
- hprot  in  4  protection; accepted, ignored
- hwdata  in  DATA_WIDTH  write data (data phase)
- hwstrb  in  DATA_WIDTH/8  write strobes (data phase)
- hready  in  1  combined transfer completion
- hrdata  out  DATA_WIDTH  read data
- hreadyout  out  1  subordinate ready
- hresp  out  1  0=OKAY 1=ERROR

Behaviour:
- Reset (async assert, sync release): state=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, pending transfer cleared. Memory contents not reset. Reset mid-transfer drops any pending write.
- Address-phase accept: hsel & hready & htrans[1] at a rising edge. On accept, register haddr, hwrite, hsize.
- IDLE/BUSY with hsel & hready: no accept; zero-wait OKAY.
- hready=0: no accept, whatever hsel is (another subordinate's data phase may be in progress).
- Word index = haddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
- Error conditions, evaluated at accept:
  - (8<<hsize) > DATA_WIDTH
  - haddr not aligned to the hsize byte count
  - word index >= MEM_DEPTH
- States:
  - IDLE: hreadyout=1, hresp=0. Accept with error -> ERR1. Accept, no error, WAIT_STATES>0 -> WAIT with counter=WAIT_STATES. Accept, no error, WAIT_STATES=0 -> DATA.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle. Counter reaching 1 -> DATA.
  - DATA: hreadyout=1, hresp=0. This is the completing cycle. Write is committed at the closing edge. Next state comes from the accept test on the same edge (back-to-back pipelining): IDLE, WAIT, DATA or ERR1.
  - ERR1: hreadyout=0, hresp=1, no memory access -> ERR2.
  - ERR2: hreadyout=1, hresp=1. Accept test applies as in DATA; an IDLE cancel by the manager -> IDLE.
- Write lanes:
  - Size mask = lanes [addr_low +: 2^hsize], using the registered values.
  - Effective lanes = size mask AND hwstrb sampled in the completing DATA cycle.
  - Only effective lanes are updated; hwstrb=0 writes nothing and still returns OKAY.
- Read data:
  - hrdata = mem[registered index] (full word, all lanes) while state=DATA and the registered transfer is a read.
  - hrdata = 0 in every other state and for writes.
  - A read whose address phase overlaps the data phase of a write to the same word returns the newly written data, because the write is committed before the read's data phase.
- Latency: OKAY transfer completes WAIT_STATES+1 cycles after accept. ERROR completes 2 cycles after accept.
- hsel dropped during WAIT/ERR1: the in-flight transfer still completes.

Test Plan:
- Reset: assert hreset mid-WAIT (WAIT_STATES=3) -> immediately hreadyout=1, hresp=0, hrdata=0; a subsequent read of the write target returns the old value.
- Zero-wait pipelined: NONSEQ write 0x10 data 0xDEADBEEF (hwstrb=F), then NONSEQ read 0x10 in its data phase -> read completes next cycle with hrdata=0xDEADBEEF, hresp=0, no hreadyout low.
- Byte lanes: write WORD 0x11223344 to 0x20, then BYTE write 0xAA at 0x22 (hwdata=0x00AA0000, hwstrb=F) -> read 0x20 returns 0x11AA3344; HALFWORD write at 0x20 with hwstrb=0 -> value unchanged.
- Wait states: WAIT_STATES=2, single read -> hreadyout low exactly 2 cycles, then high with data; INCR4 burst -> each beat is 3 cycles.
- Errors: read at 0x401 with hsize=WORD (misaligned), and read at 0x400 (index 256 >= MEM_DEPTH) -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); HSIZE=DOUBLEWORD with DATA_WIDTH=32 -> ERROR.
- IDLE/BUSY/hready low: IDLE, BUSY, and hsel with hready=0 -> no state change, OKAY, memory untouched.
